// File: rtl/imu_pkg.sv
// Shared definitions for the IMU front end: burst layout, word type and
// small helpers used by the byte assembler and the conditioner.
package imu_pkg;

  localparam int FRAME_BYTES = 14;
  localparam int ACC_X  = 0;
  localparam int ACC_Y  = 2;
  localparam int GYRO_X = 8;
  localparam int GYRO_Y = 10;
  localparam int GYRO_Z = 12;

  typedef logic signed [15:0] imu_word_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_PROCESS
  } asm_state_t;

  // Byte k of the burst lives at frame[k*8 +: 8]; words are big-endian.
  function automatic imu_word_t frame_word(input logic [FRAME_BYTES*8-1:0] frame,
                                           input int off);
    return imu_word_t'({frame[off*8 +: 8], frame[(off+1)*8 +: 8]});
  endfunction

  function automatic imu_word_t sat16(input logic signed [16:0] v);
    if (v > 17'sd32767)
      return imu_word_t'(16'h7FFF);
    else if (v < -17'sd32768)
      return imu_word_t'(16'h8000);
    return imu_word_t'(v[15:0]);
  endfunction

endpackage

// File: rtl/imu_byte_assembler.sv
// Collects the 14-byte burst, tracks the byte index and inter-byte gap,
// and flags aborted frames. frame_done is high for the single PROCESS cycle.
module imu_byte_assembler
  import imu_pkg::*;
#(
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     byte_valid,
  input  logic [7:0]               byte_data,
  input  logic                     frame_start,
  output logic [FRAME_BYTES*8-1:0] frame,
  output logic                     frame_done,
  output logic                     frame_err
);

  localparam int GAP_W = $clog2(TIMEOUT_CYC + 1);

  asm_state_t       state_reg, state_next;
  logic [3:0]       idx_reg, idx_next;
  logic [GAP_W-1:0] gap_reg, gap_next;
  logic             err_reg, err_next;
  logic             wr_en;
  logic [3:0]       wr_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      idx_reg   <= '0;
      gap_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      gap_reg   <= gap_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    gap_next   = gap_reg;
    err_next   = 1'b0;
    wr_en      = 1'b0;
    wr_idx     = idx_reg;
    case (state_reg)
      ST_IDLE: begin
        gap_next = '0;
        if (byte_valid && frame_start) begin
          wr_en      = 1'b1;
          wr_idx     = 4'd0;
          idx_next   = 4'd1;
          state_next = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (byte_valid) begin
          gap_next = '0;
          wr_en    = 1'b1;
          if (frame_start) begin
            // Restart: drop the partial frame and take this byte as byte 0.
            err_next = 1'b1;
            wr_idx   = 4'd0;
            idx_next = 4'd1;
          end else if (idx_reg == 4'(FRAME_BYTES - 1)) begin
            idx_next   = 4'd0;
            state_next = ST_PROCESS;
          end else begin
            idx_next = idx_reg + 4'd1;
          end
        end else if (gap_reg == GAP_W'(TIMEOUT_CYC - 1)) begin
          err_next   = 1'b1;
          idx_next   = 4'd0;
          gap_next   = '0;
          state_next = ST_IDLE;
        end else begin
          gap_next = gap_reg + GAP_W'(1);
        end
      end
      ST_PROCESS: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
        idx_next   = 4'd0;
      end
    endcase
  end

  generate
    for (genvar gi = 0; gi < FRAME_BYTES; gi++) begin : g_byte
      logic [7:0] byte_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          byte_reg <= '0;
        else if (wr_en && (wr_idx == 4'(gi)))
          byte_reg <= byte_data;
      end
      assign frame[gi*8 +: 8] = byte_reg;
    end
  endgenerate

  assign frame_done = (state_reg == ST_PROCESS);
  assign frame_err  = err_reg;

endmodule

// File: rtl/imu_frame_conditioner.sv
// Turns assembled MPU6050 bursts into bias-corrected gyro and scaled acc words
// for the attitude filter, and runs the gyro bias calibration.
module imu_frame_conditioner
  import imu_pkg::*;
#(
  parameter int CAL_LOG2    = 8,
  parameter int ACC_SHIFT   = 0,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  input  logic              frame_start,
  input  logic              cal_start,
  output logic signed [15:0] pitch_gyro,
  output logic signed [15:0] roll_gyro,
  output logic signed [15:0] yaw_gyro,
  output logic signed [15:0] pitch_acc,
  output logic signed [15:0] roll_acc,
  output logic              sample_valid,
  output logic              cal_busy,
  output logic              cal_done,
  output logic              frame_err
);

  localparam int ACC_W = 16 + CAL_LOG2;

  logic [FRAME_BYTES*8-1:0] frame;
  logic                     frame_done;

  imu_byte_assembler #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_assembler (
    .clk        (clk),
    .rst_n      (rst_n),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_start(frame_start),
    .frame      (frame),
    .frame_done (frame_done),
    .frame_err  (frame_err)
  );

  logic                cal_busy_reg, cal_done_reg, sample_valid_reg;
  logic [CAL_LOG2-1:0] cal_cnt_reg;
  imu_word_t           pitch_acc_reg, roll_acc_reg;
  imu_word_t           gyro_out [3];
  logic                cal_begin, cal_frame, cal_last, update;

  assign cal_begin = cal_start && !cal_busy_reg;
  assign cal_frame = frame_done && cal_busy_reg;
  // The counter is all ones exactly on the 2^CAL_LOG2-th calibration frame.
  assign cal_last  = cal_frame && (cal_cnt_reg == '1);
  assign update    = frame_done && !cal_busy_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cal_busy_reg     <= 1'b0;
      cal_done_reg     <= 1'b0;
      sample_valid_reg <= 1'b0;
      cal_cnt_reg      <= '0;
      pitch_acc_reg    <= '0;
      roll_acc_reg     <= '0;
    end else begin
      sample_valid_reg <= update;
      cal_done_reg     <= cal_last;
      if (cal_last)
        cal_busy_reg <= 1'b0;
      else if (cal_begin)
        cal_busy_reg <= 1'b1;
      if (cal_begin)
        cal_cnt_reg <= '0;
      else if (cal_frame)
        cal_cnt_reg <= cal_cnt_reg + 1'b1;
      if (update) begin
        pitch_acc_reg <= frame_word(frame, ACC_X) >>> ACC_SHIFT;
        roll_acc_reg  <= frame_word(frame, ACC_Y) >>> ACC_SHIFT;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_axis
      imu_word_t               raw;
      imu_word_t               bias_reg, out_reg;
      logic signed [ACC_W-1:0] accum_reg, accum_sum;

      assign raw       = frame_word(frame, GYRO_X + 2 * gi);
      assign accum_sum = accum_reg + ACC_W'(raw);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          accum_reg <= '0;
          bias_reg  <= '0;
          out_reg   <= '0;
        end else begin
          if (cal_begin)
            accum_reg <= '0;
          else if (cal_frame)
            accum_reg <= accum_sum;
          // Arithmetic shift gives the floor of the average, negative included.
          if (cal_last)
            bias_reg <= imu_word_t'(accum_sum >>> CAL_LOG2);
          if (update)
            out_reg <= sat16(17'(raw) - 17'(bias_reg));
        end
      end

      assign gyro_out[gi] = out_reg;
    end
  endgenerate

  assign pitch_gyro   = gyro_out[0];
  assign roll_gyro    = gyro_out[1];
  assign yaw_gyro     = gyro_out[2];
  assign pitch_acc    = pitch_acc_reg;
  assign roll_acc     = roll_acc_reg;
  assign sample_valid = sample_valid_reg;
  assign cal_busy     = cal_busy_reg;
  assign cal_done     = cal_done_reg;

endmodule

// File: tb/tb_imu_frame_conditioner.sv
// Randomized bench for imu_frame_conditioner against an arithmetic model of
// bias removal, saturation, calibration averaging and frame abort rules.
module tb_imu_frame_conditioner;

  localparam int CAL_LOG2    = 8;
  localparam int ACC_SHIFT   = 0;
  localparam int TIMEOUT_CYC = 4096;
  localparam int CAL_N       = 1 << CAL_LOG2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              byte_valid = 1'b0;
  logic [7:0]        byte_data = '0;
  logic              frame_start = 1'b0;
  logic              cal_start = 1'b0;
  logic signed [15:0] pitch_gyro, roll_gyro, yaw_gyro, pitch_acc, roll_acc;
  logic              sample_valid, cal_busy, cal_done, frame_err;

  imu_frame_conditioner #(
    .CAL_LOG2   (CAL_LOG2),
    .ACC_SHIFT  (ACC_SHIFT),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .frame_start (frame_start),
    .cal_start   (cal_start),
    .pitch_gyro  (pitch_gyro),
    .roll_gyro   (roll_gyro),
    .yaw_gyro    (yaw_gyro),
    .pitch_acc   (pitch_acc),
    .roll_acc    (roll_acc),
    .sample_valid(sample_valid),
    .cal_busy    (cal_busy),
    .cal_done    (cal_done),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int sv_cnt = 0, err_cnt = 0, done_cnt = 0;
  logic s_sv, s_err, s_done;
  logic [7:0] fb [14];

  // Reference state
  int  bias_m [3];
  bit  cal_m;
  int  cal_n;
  int  sum_m [3];

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int sat(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic int floor_div(input int s, input int n);
    int q;
    q = s / n;
    if ((s % n != 0) && (s < 0)) q = q - 1;
    return q;
  endfunction

  function automatic int rnd16();
    logic signed [15:0] r;
    r = 16'($urandom);
    return int'(r);
  endfunction

  // One clock: sample outputs on the falling edge, then step past the rising edge.
  task automatic tick();
    @(negedge clk);
    s_sv   = sample_valid;
    s_err  = frame_err;
    s_done = cal_done;
    sv_cnt   += int'(s_sv);
    err_cnt  += int'(s_err);
    done_cnt += int'(s_done);
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic fs, input int gap);
    repeat (gap) tick();
    byte_valid  = 1'b1;
    byte_data   = b;
    frame_start = fs;
    tick();
    byte_valid  = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic build(input int gx, input int gy, input int gz, input int ax, input int ay);
    logic [15:0] w [7];
    w[0] = 16'(ax);
    w[1] = 16'(ay);
    w[2] = 16'($urandom);
    w[3] = 16'($urandom);
    w[4] = 16'(gx);
    w[5] = 16'(gy);
    w[6] = 16'(gz);
    for (int k = 0; k < 7; k++) begin
      fb[2*k]   = w[k][15:8];
      fb[2*k+1] = w[k][7:0];
    end
  endtask

  task automatic send_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++)
      send_byte(fb[i], i == 0, (i == lo) ? 0 : int'($urandom_range(0, 1)));
  endtask

  task automatic partial_frame(input int nbytes);
    build(rnd16(), rnd16(), rnd16(), rnd16(), rnd16());
    send_range(0, nbytes - 1);
  endtask

  task automatic start_cal();
    cal_start = 1'b1;
    tick();
    cal_start = 1'b0;
    if (!cal_m) begin
      cal_m = 1'b1;
      cal_n = 0;
      for (int a = 0; a < 3; a++) sum_m[a] = 0;
    end
    check("cal_busy_after_start", int'(cal_busy), int'(cal_m));
  endtask

  task automatic run_frame(input int gx, input int gy, input int gz, input int ax,
                           input int ay, input bit cal_in_process);
    int  g [3];
    int  eg [3];
    bit  exp_sv, exp_done, was_busy;
    g[0] = gx; g[1] = gy; g[2] = gz;
    build(gx, gy, gz, ax, ay);
    send_range(0, 13);
    was_busy = cal_m;
    exp_sv   = !was_busy;
    exp_done = 1'b0;
    for (int a = 0; a < 3; a++) eg[a] = sat(g[a] - bias_m[a]);
    if (was_busy) begin
      cal_n++;
      for (int a = 0; a < 3; a++) sum_m[a] += g[a];
      if (cal_n == CAL_N) begin
        for (int a = 0; a < 3; a++) bias_m[a] = floor_div(sum_m[a], CAL_N);
        cal_m    = 1'b0;
        exp_done = 1'b1;
      end
    end else if (cal_in_process) begin
      cal_m = 1'b1;
      cal_n = 0;
      for (int a = 0; a < 3; a++) sum_m[a] = 0;
    end
    if (cal_in_process) cal_start = 1'b1;
    tick();
    cal_start = 1'b0;
    check("sample_valid_early", int'(s_sv), 0);
    tick();
    check("sample_valid", int'(s_sv), int'(exp_sv));
    check("cal_done", int'(s_done), int'(exp_done));
    check("cal_busy", int'(cal_busy), int'(cal_m));
    if (exp_sv) begin
      check("pitch_gyro", int'(pitch_gyro), eg[0]);
      check("roll_gyro", int'(roll_gyro), eg[1]);
      check("yaw_gyro", int'(yaw_gyro), eg[2]);
      check("pitch_acc", int'(pitch_acc), ax >>> ACC_SHIFT);
      check("roll_acc", int'(roll_acc), ay >>> ACC_SHIFT);
      $display("frame gyro=(%0d,%0d,%0d) -> out=(%0d,%0d,%0d) acc=(%0d,%0d)",
               gx, gy, gz, pitch_gyro, roll_gyro, yaw_gyro, pitch_acc, roll_acc);
    end
    tick();
  endtask

  task automatic model_reset();
    for (int a = 0; a < 3; a++) begin
      bias_m[a] = 0;
      sum_m[a]  = 0;
    end
    cal_m = 1'b0;
    cal_n = 0;
  endtask

  task automatic calibrate_const(input int gx, input int gy, input int gz);
    start_cal();
    for (int f = 0; f < CAL_N; f++) run_frame(gx, gy, gz, rnd16(), rnd16(), 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e0, v0, d0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_pitch_gyro", int'(pitch_gyro), 0);
    check("reset_yaw_gyro", int'(yaw_gyro), 0);
    check("reset_roll_acc", int'(roll_acc), 0);
    check("reset_sample_valid", int'(sample_valid), 0);
    check("reset_cal_busy", int'(cal_busy), 0);
    rst_n = 1'b1;
    tick();

    // Basic frame, zero bias
    run_frame(256, -256, 32767, 4096, -4096, 1'b0);

    // Constant calibration, with a redundant cal_start while busy
    start_cal();
    d0 = done_cnt; v0 = sv_cnt;
    for (int f = 0; f < CAL_N; f++) begin
      run_frame(10, -3, 7, rnd16(), rnd16(), 1'b0);
      if (f == 100) start_cal();
    end
    check("cal_done_count", done_cnt - d0, 1);
    check("cal_no_sample_valid", sv_cnt - v0, 0);
    run_frame(10, -3, 7, rnd16(), rnd16(), 1'b0);

    // Saturation at both rails
    calibrate_const(-100, -100, -100);
    run_frame(32752, 0, -32768, rnd16(), rnd16(), 1'b0);
    calibrate_const(100, 100, 100);
    run_frame(-32752, 0, 32767, rnd16(), rnd16(), 1'b0);

    // cal_start during PROCESS: old bias applies, then random-noise calibration
    run_frame(rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), 1'b1);
    for (int f = 0; f < CAL_N; f++)
      run_frame(int'($urandom_range(0, 4000)) - 2000, int'($urandom_range(0, 4000)) - 2000,
                int'($urandom_range(0, 600)) - 300, rnd16(), rnd16(), 1'b0);
    for (int f = 0; f < 30; f++)
      run_frame(rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), 1'b0);

    // Restart mid-frame
    e0 = err_cnt; v0 = sv_cnt;
    partial_frame(5);
    run_frame(rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), 1'b0);
    check("restart_frame_err", err_cnt - e0, 1);
    check("restart_one_sample", sv_cnt - v0, 1);

    // Inter-byte timeout and stray bytes
    e0 = err_cnt; v0 = sv_cnt;
    partial_frame(10);
    repeat (TIMEOUT_CYC - 2) tick();
    check("timeout_not_early", err_cnt - e0, 0);
    repeat (6) tick();
    check("timeout_frame_err", err_cnt - e0, 1);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b0, 1);
    repeat (4) tick();
    check("stray_no_sample", sv_cnt - v0, 0);
    run_frame(rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), 1'b0);
    check("timeout_idle_no_err", err_cnt - e0, 1);

    // Reset in the middle of calibration
    start_cal();
    for (int f = 0; f < 99; f++) run_frame(rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), 1'b0);
    partial_frame(6);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_cal_busy", int'(cal_busy), 0);
    check("rst_pitch_gyro", int'(pitch_gyro), 0);
    check("rst_pitch_acc", int'(pitch_acc), 0);
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    run_frame(rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), 1'b0);
    run_frame(-32768, 32767, 1, rnd16(), rnd16(), 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
